derandomizer_rx: RTL
====================

// Module: derandomizer_rx
// PURPOSE
//  Receive-side companion of the CCSDS Gold-sequence randomizer (CCSDS 131.2 App. C).
//  Hunts the 32-bit attached sync marker (ASM) in a 2-bit symbol stream and restarts the
//  Gold sequence at each frame start. XORs every payload symbol with the 2-bit key and
//  forwards it downstream, giving the derandomized stream.
//  Sits between the demodulator symbol slicer and the frame decoder.
// PARAMETERS
//  FRAME_SYMS  4096          payload symbols per frame after the ASM (2 bits/symbol, >=2)
//  ASM_WORD    32'h1ACFFC1D  sync marker; first-received bit = bit 31
// PORTS
//  i_clk      in   1  clock
//  i_reset    in   1  reset, asynchronous, active-high
//  i_sym      in   2  input symbol; i_sym[1] is the earlier bit on the line
//  i_valid    in   1  input symbol valid
//  o_ready    out  1  input accept; transfer when i_valid && o_ready
//  o_sym      out  2  derandomized payload symbol
//  o_valid    out  1  output valid
//  i_ready    in   1  downstream accept
//  o_sof      out  1  qualifies o_sym as the first payload symbol of a frame
//  o_locked   out  1  high while in FRAME/CHECK (and FLY when enabled)
// BEHAVIOUR
//  Reset: o_valid=0, o_sof=0, o_locked=0, o_sym=0, state=HUNT, shift reg=0,
//   x=18'h00001, y=18'h3FFFF, counter=0.
//  Key generator (x,y 18-bit, state advances once per accepted payload symbol):
//   x' = {x[7]^x[0], x[17:1]};  y' = {y[10]^y[7]^y[5]^y[0], y[17:1]}
//   key = {x[4]^x[6]^x[15]^(^y[15:5] excluding y[7]), x[0]^y[0]}
//    (z2 term = y5^y6^y8^y9^y10^y11^y12^y13^y14^y15)
//  Output stage is a single register: o_ready = !o_valid || i_ready.
//   Latency is 1 cycle from input accept to o_valid.
//  States:
//   HUNT:  each accepted symbol shifts into a 32-bit sreg ({sreg[29:0],i_sym}).
//          When the post-shift value equals ASM_WORD: load x/y to init, counter=0,
//          go to FRAME. Nothing is output in HUNT.
//   FRAME: accepted symbol -> o_sym = i_sym ^ key, o_valid=1, o_sof=(counter==0).
//          Advance x/y and increment counter. After symbol FRAME_SYMS-1, clear the
//          counter and go to CHECK.
//   CHECK: the next 16 accepted symbols shift into sreg and are not output.
//          On the 16th symbol: sreg==ASM_WORD -> reload x/y, go to FRAME.
//          Mismatch -> HUNT, or FLY when the option is enabled.
//  A partial ASM match in HUNT is not remembered across a false start. Sliding
//   compare handles overlap naturally.
//  An ASM pattern appearing inside the payload while in FRAME is ignored.
//  Back-pressure (i_ready=0 with o_valid=1) holds o_sym/o_sof and stalls input.
//   Key state does not advance while stalled.
//  i_reset mid-frame: immediate return to reset values. The partial frame is discarded.
// CONFIGURATION
//  DERAND_FLYWHEEL_EN defined: CHECK mismatch -> FLY state.
//   FLY derandomizes one more frame exactly as FRAME (x/y reloaded to init, o_sof on first).
//   o_locked stays 1; then CHECK again.
//   A second consecutive mismatch -> HUNT. A match in CHECK clears the miss count.
//  Not defined: the FLY state is absent. Any CHECK mismatch -> HUNT, o_locked=0 next cycle.
// STRUCTURE
//  Package derand_pkg: state enum (HUNT/FRAME/CHECK/FLY), X_INIT=18'h00001,
//   Y_INIT=18'h3FFFF, ASM_SYMS=16.
//  Sub-module gold_key_gen: x/y LFSRs with i_load (to init), i_step, o_key[1:0].
//   Combinational key output; shared with the transmit side.
// TESTING
//  1 Reset, send ASM then payload 00,00 -> o_sym 00 (o_sof=1), then 01; o_locked=1.
//  2 Loopback: randomizer TX + ASM framing, 3 frames FRAME_SYMS=64 random data ->
//    output equals original data; o_sof once per frame.
//  3 Corrupt one bit of 2nd ASM -> o_locked=0 after CHECK and no output until next
//    clean ASM; flywheel build: locked, 3rd frame still correct.
//  4 Hold i_ready=0 for 5 cycles mid-frame -> o_sym/o_sof stable, o_ready=0, no symbol lost.
//  5 Assert i_reset at payload symbol 30 -> all outputs 0 next edge; re-hunt locks on next ASM.
//  6 Random junk then ASM shifted by 1 symbol offset -> lock exactly after ASM's last symbol.

Source files
------------

// File: rtl/derand_pkg.sv
// Shared definitions for the CCSDS Gold-sequence derandomizer.
//  - state_t  : receiver framing states
//  - X_INIT / Y_INIT : Gold LFSR seeds loaded at every frame start
//  - ASM_SYMS : attached sync marker length in 2-bit symbols
package derand_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        FRAME = 2'd1,
        CHECK = 2'd2,
        FLY   = 2'd3
    } state_t;

    localparam logic [17:0] X_INIT   = 18'h00001;
    localparam logic [17:0] Y_INIT   = 18'h3FFFF;
    localparam int          ASM_SYMS = 16;

endpackage

// File: rtl/gold_key_gen.sv
// Gold-sequence key generator (two 18-bit Fibonacci LFSRs x and y).
// Produces a 2-bit key per symbol; identical on transmit and receive sides.
// Ports:
//  i_clk, i_reset : clock, asynchronous active-high reset (seeds loaded)
//  i_load         : reload x/y with their seeds (takes priority over i_step)
//  i_step         : advance both LFSRs by one symbol
//  o_key[1:0]     : key for the current symbol, combinational from x/y
module gold_key_gen
    import derand_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic       i_step,
    output logic [1:0] o_key
);

    logic [17:0] r_x;
    logic [17:0] r_y;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_x <= X_INIT;
            r_y <= Y_INIT;
        end else if (i_load) begin
            r_x <= X_INIT;
            r_y <= Y_INIT;
        end else if (i_step) begin
            r_x <= {r_x[7] ^ r_x[0], r_x[17:1]};
            r_y <= {r_y[10] ^ r_y[7] ^ r_y[5] ^ r_y[0], r_y[17:1]};
        end
    end

    // Upper key bit mixes shifted taps of x with the y "z2" term (y5..y15 without y7).
    logic w_z2;
    assign w_z2  = r_y[5] ^ r_y[6] ^ r_y[8] ^ r_y[9] ^ r_y[10] ^ r_y[11]
                 ^ r_y[12] ^ r_y[13] ^ r_y[14] ^ r_y[15];
    assign o_key = {r_x[4] ^ r_x[6] ^ r_x[15] ^ w_z2, r_x[0] ^ r_y[0]};

endmodule

// File: rtl/derandomizer_rx.sv
// Receive-side CCSDS derandomizer. Hunts the 32-bit ASM in a 2-bit symbol stream,
// restarts the Gold sequence at each frame start and XORs payload symbols with it.
// Optional macro DERAND_FLYWHEEL_EN: one missed ASM is tolerated (FLY state keeps
// derandomizing one frame); without it any ASM miss returns to HUNT.
// Ports:
//  i_clk, i_reset  : clock, asynchronous active-high reset
//  i_sym, i_valid  : input symbol (i_sym[1] earlier on the line) and valid
//  o_ready         : input accept (= output register free or draining)
//  o_sym, o_valid  : derandomized payload symbol and valid
//  i_ready         : downstream accept
//  o_sof           : o_sym is the first payload symbol of a frame
//  o_locked        : framing acquired (FRAME/CHECK/FLY)
module derandomizer_rx
    import derand_pkg::*;
#(
    parameter int          FRAME_SYMS = 4096,
    parameter logic [31:0] ASM_WORD   = 32'h1ACFFC1D
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_sym,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [1:0] o_sym,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_sof,
    output logic       o_locked
);

    // Counter covers both the payload index and the ASM index inside CHECK.
    localparam int CW = $clog2(FRAME_SYMS + ASM_SYMS);

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    // Only the last 30 bits need keeping: the compare uses them plus the new symbol.
    logic [29:0]    r_sreg, w_sreg_nxt;
    logic [31:0]    w_sreg_sh;
    logic           w_acc, w_load, w_step, w_emit;
    logic           w_last_pay, w_last_chk, w_asm_hit;
    logic [1:0]     w_key;
    logic           r_valid, r_sof;
    logic [1:0]     r_sym;
`ifdef DERAND_FLYWHEEL_EN
    logic           r_miss, w_miss_nxt;
`endif

    assign o_ready    = !r_valid || i_ready;
    assign w_acc      = i_valid && o_ready;
    assign w_sreg_sh  = {r_sreg, i_sym};
    assign w_asm_hit  = (w_sreg_sh == ASM_WORD);
    assign w_last_pay = (r_cnt == CW'(FRAME_SYMS - 1));
    assign w_last_chk = (r_cnt == CW'(ASM_SYMS - 1));

    gold_key_gen u_key (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_step  (w_step),
        .o_key   (w_key)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= HUNT;
            r_cnt   <= '0;
            r_sreg  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sreg  <= w_sreg_nxt;
        end
    end

`ifdef DERAND_FLYWHEEL_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_miss <= 1'b0;
        else         r_miss <= w_miss_nxt;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sreg_nxt  = r_sreg;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_emit      = 1'b0;
`ifdef DERAND_FLYWHEEL_EN
        w_miss_nxt  = r_miss;
`endif
        if (w_acc) begin
            case (r_state)
                HUNT: begin
                    w_sreg_nxt = w_sreg_sh[29:0];
                    if (w_asm_hit) begin
                        w_load      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = FRAME;
                    end
                end
                FRAME, FLY: begin
                    // Payload is never searched for the ASM.
                    w_emit = 1'b1;
                    w_step = 1'b1;
                    if (w_last_pay) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = CHECK;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    w_sreg_nxt = w_sreg_sh[29:0];
                    if (w_last_chk) begin
                        w_cnt_nxt = '0;
                        if (w_asm_hit) begin
                            w_load      = 1'b1;
                            w_state_nxt = FRAME;
`ifdef DERAND_FLYWHEEL_EN
                            w_miss_nxt  = 1'b0;
`endif
                        end else begin
`ifdef DERAND_FLYWHEEL_EN
                            if (!r_miss) begin
                                w_load      = 1'b1;
                                w_state_nxt = FLY;
                                w_miss_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = HUNT;
                                w_miss_nxt  = 1'b0;
                            end
`else
                            w_state_nxt = HUNT;
`endif
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // Single output register; it only moves when the downstream slot is free.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_sym   <= '0;
        end else if (o_ready) begin
            r_valid <= w_emit;
            r_sof   <= w_emit && (r_cnt == '0);
            if (w_emit) r_sym <= i_sym ^ w_key;
        end
    end

    assign o_valid  = r_valid;
    assign o_sof    = r_sof;
    assign o_sym    = r_sym;
    assign o_locked = (r_state != HUNT);

endmodule
